// File: rtl/booth_seq_multiplier.sv
// Sequential radix-2 Booth multiplier: one add/subtract-then-shift step per clock,
// start/busy/done handshake, product held until the next completion.
module booth_seq_multiplier #(
  parameter int unsigned WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned AW = WIDTH + 1;
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   m_q, m_d;
  logic [AW-1:0]   a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic            qm1_q, qm1_d;
  logic [CW-1:0]   count_q, count_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [PW-1:0]   product_q, product_d;
  logic [AW-1:0]   a_sum;

  // Next-state: accept in IDLE, one Booth step per cycle in RUN, publish on last step
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    a_d       = a_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    count_d   = count_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    product_d = product_q;
    a_sum     = a_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = {multiplicand[WIDTH-1], multiplicand};
          a_d     = '0;
          q_d     = multiplier;
          qm1_d   = 1'b0;
          count_d = CW'(WIDTH);
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        // A is one bit wider than the operands, so A - M never overflows
        unique case ({q_q[0], qm1_q})
          2'b01:   a_sum = a_q + m_q;
          2'b10:   a_sum = a_q - m_q;
          default: a_sum = a_q;
        endcase
        a_d     = {a_sum[AW-1], a_sum[AW-1:1]};
        q_d     = {a_sum[0], q_q[WIDTH-1:1]};
        qm1_d   = q_q[0];
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          product_d = {a_d[WIDTH-1:0], q_d};
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      m_q       <= '0;
      a_q       <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      a_q       <= a_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Randomized and directed bench for booth_seq_multiplier against an integer product model.
module tb_booth_seq_multiplier;

  localparam int unsigned W  = 5;
  localparam int unsigned PW = 2 * W;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  multiplicand;
  logic [W-1:0]  multiplier;
  logic          busy;
  logic          done;
  logic [PW-1:0] product;

  int total;
  int bad;

  booth_seq_multiplier #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: signed integer product truncated to the product width
  function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    int sa;
    int sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    return PW'(sa * sb);
  endfunction

  // Full transaction with cycle-accurate handshake checks; inputs driven at negedge
  task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    logic [PW-1:0] prev;
    @(negedge clk);
    check({tag, "_done_low_before"}, 32'(done), 32'd0);
    prev         = product;
    start        = 1'b1;
    multiplicand = a;
    multiplier   = b;
    @(negedge clk);
    start        = 1'b0;
    multiplicand = W'($urandom);
    multiplier   = W'($urandom);
    for (int i = 0; i < int'(W); i++) begin
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_done_early"}, 32'(done), 32'd0);
      if (i == 2) check({tag, "_prod_hold"}, 32'(product), 32'(prev));
      @(negedge clk);
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_off"}, 32'(busy), 32'd0);
    check({tag, "_prod"}, 32'(product), 32'(ref_mul(a, b)));
  endtask

  initial begin
    int done_cnt;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    total        = 0;
    bad          = 0;
    rst_n        = 1'b0;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;

    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_prod", 32'(product), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases with hand-computed products
    do_mul(5'd3, 5'd5, "m3x5");
    check("m3x5_const", 32'(product), 32'h00F);
    do_mul(5'h19, 5'h06, "mneg7x6");
    check("mneg7x6_const", 32'(product), 32'h3D6);
    do_mul(5'h10, 5'h10, "mneg16sq");
    check("mneg16sq_const", 32'(product), 32'h100);
    do_mul(5'h0F, 5'h1F, "m15xneg1");
    check("m15xneg1_const", 32'(product), 32'h3F1);

    // Back-to-back with start held high: 0 x -6 then 15 x 15, one result per 6 cycles
    @(negedge clk);
    start = 1'b1; multiplicand = 5'h00; multiplier = 5'h1A;
    for (int i = 0; i < int'(W); i++) begin
      @(negedge clk);
      check("b2b_busy1", 32'(busy), 32'd1);
    end
    @(negedge clk);
    check("b2b_done1", 32'(done), 32'd1);
    check("b2b_prod1", 32'(product), 32'h000);
    multiplicand = 5'h0F; multiplier = 5'h0F;
    for (int i = 0; i < int'(W); i++) begin
      @(negedge clk);
      check("b2b_busy2", 32'(busy), 32'd1);
      check("b2b_prodhold", 32'(product), 32'h000);
    end
    @(negedge clk);
    start = 1'b0;
    check("b2b_done2", 32'(done), 32'd1);
    check("b2b_prod2", 32'(product), 32'h0E1);
    @(negedge clk);
    check("b2b_idle", 32'(busy), 32'd0);

    // start toggling during RUN must be ignored
    start = 1'b1; multiplicand = 5'd3; multiplier = 5'd5;
    done_cnt = 0;
    for (int i = 0; i < int'(W) + 1; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
      start        = (i % 2 == 0) ? 1'b0 : 1'b1;
      multiplicand = W'($urandom);
      multiplier   = W'($urandom);
      if (i == int'(W)) start = 1'b0;
    end
    check("tog_done", 32'(done), 32'd1);
    check("tog_prod", 32'(product), 32'h00F);
    check("tog_done_cnt", 32'(done_cnt), 32'd1);

    // Reset in the middle of a run clears everything at once
    @(negedge clk);
    start = 1'b1; multiplicand = 5'd9; multiplier = 5'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_busy_pre", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_done", 32'(done), 32'd0);
    check("mid_prod", 32'(product), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < int'(W) + 2; i++) begin
      @(negedge clk);
      if (done || busy) done_cnt++;
    end
    check("mid_no_done", 32'(done_cnt), 32'd0);
    do_mul(5'd2, 5'd2, "post_rst");
    check("post_rst_const", 32'(product), 32'h004);

    // Randomized operands against the integer model
    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      do_mul(ra, rb, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
